car_move_sched: RTL and testbench
=================================

CAR_MOVE_SCHED -- requirements
Module: car_move_sched

Interface
REQ-001 The block SHALL take parameter N_CARS, default 2, meaning number of cars scheduled.
REQ-002 The block SHALL take parameter TICK_DIV, default 262144, meaning clk cycles per game tick.
REQ-003 The block SHALL take parameters CAR_W, default 51, and CAR_H, default 30, meaning on-screen car width and height in pixels.
REQ-004 The block SHALL take parameters MAX_X, default 1279, and MAX_Y, default 799, meaning last legal screen column and row.
REQ-005 The block SHALL take parameter PROBE_LAT, default 2, meaning clk cycles from probe_valid to a valid walkable.
REQ-006 The block SHALL take parameters INIT_X, default {416,416}, and INIT_Y, default {192,256}, meaning per-car reset position.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  synchronous, active-low reset.
REQ-009 dir_req  in  N_CARS x 4  per-car {up,down,left,right} request, level-sensitive.
REQ-010 walkable  in  1  collision-mask result for the last probe.
REQ-011 probe_valid  out  1  single-cycle strobe; probe_x/probe_y are valid.
REQ-012 probe_x  out  11  probed pixel column; probe_y  out  10  probed pixel row.
REQ-013 pos_x  out  N_CARS x 11  car top-left column; pos_y  out  N_CARS x 10  car top-left row.
REQ-014 tick  out  1  one-cycle game-tick pulse.
REQ-015 busy  out  1  high while the FSM is not IDLE.
REQ-016 overrun  out  1  sticky flag; a tick arrived while busy.

Function
REQ-017 The tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for exactly the cycle in which it wraps.
REQ-018 The FSM SHALL have states IDLE, SELECT, PROBE, WAIT, COMMIT.
REQ-019 IDLE->SELECT on tick; the FSM loads the car index from rr_ptr and clears the visit count.
REQ-020 A tick arriving while busy SHALL be dropped and SHALL set overrun; the current pass SHALL be unaffected.
REQ-021 In SELECT, direction SHALL use priority up>down>left>right; no request SHALL skip the car.
REQ-022 Probe points (x=pos_x, y=pos_y): up (x,y-1); down (x,y+CAR_H); left (x-1,y); right (x+CAR_W,y).
REQ-023 Legality: up needs y>=1; down needs y+CAR_H<=MAX_Y; left needs x>=1; right needs x+CAR_W<=MAX_X; an illegal move SHALL skip the car without a probe.
REQ-024 Arithmetic for REQ-022 and REQ-023 SHALL be done at least 12 bits wide, so that no wrap occurs.
REQ-025 SELECT->PROBE for a legal move; PROBE SHALL drive probe_valid=1 for one cycle; PROBE->WAIT.
REQ-026 WAIT SHALL hold for PROBE_LAT-1 cycles, then go to COMMIT; COMMIT SHALL sample walkable.
REQ-027 COMMIT SHALL apply a ±1 step only if walkable=1 and the new box does not overlap any other car's current box (half-open rectangles).
REQ-028 After COMMIT or a skip, the FSM SHALL advance to the next car (mod N_CARS); after N_CARS visits it SHALL go to IDLE and set rr_ptr=rr_ptr+1 mod N_CARS.
REQ-029 Cars visited earlier in a pass SHALL be seen at their updated positions by later overlap checks.
REQ-030 Latency: with tick in cycle T, probe_valid SHALL occur at T+2 and the pos update SHALL be visible at T+3+PROBE_LAT.
REQ-031 Changes on dir_req SHALL be ignored except when sampled in SELECT.
REQ-032 probe_x/probe_y SHALL hold their last value when probe_valid=0.

Reset
REQ-033 On rst=0 at a clk edge, the block SHALL set: counter=0, FSM=IDLE, rr_ptr=0, tick=0, busy=0, overrun=0, probe_valid=0, probe_x=0, probe_y=0, pos=INIT.
REQ-034 A reset in any state, including WAIT, SHALL abort the pass, and no position update SHALL occur.

Structure
REQ-035 Package car_sched_pkg SHALL hold the dir_t enum, the sched_state_t enum, and the CAR_W/CAR_H/MAX_X/MAX_Y constants.
REQ-036 The tick counter SHALL be the sub-module tick_divider, with ports clk, rst, tick.

Verification (TICK_DIV=16, PROBE_LAT=2)
REQ-037 Reset -> pos0=(416,192), pos1=(416,256); tick SHALL pulse every 16 cycles; busy=0.
REQ-038 car0 up, walkable=1 -> probe (416,191) at T+2; pos0.y=191 at T+5.
REQ-039 car0 right, walkable=0 -> probe (467,192); pos0 SHALL be unchanged.
REQ-040 car0 at (0,192) left -> no probe_valid; pos unchanged; busy for N_CARS SELECT visits only.
REQ-041 car0 at (416,225), car1 at (416,256), car0 down, walkable=1 -> probe (416,255) and commit; next tick rejected by overlap.
REQ-042 TICK_DIV=4 with both cars moving -> overrun=1 and stays 1 until reset; rr_ptr SHALL alternate the first probe car per pass.

Source files
------------

// File: rtl/car_sched_pkg.sv
// Shared types and default geometry for the car movement scheduler.
package car_sched_pkg;

   localparam int unsigned CAR_W = 51;
   localparam int unsigned CAR_H = 30;
   localparam int unsigned MAX_X = 1279;
   localparam int unsigned MAX_Y = 799;

   typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_t;

   typedef enum logic [2:0] {StIdle, StSelect, StProbe, StWait, StCommit} sched_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running game-tick divider; tick_o is high in the cycle the counter wraps.
module tick_divider #(
   parameter int unsigned TICK_DIV = 262144
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/car_move_sched.sv
// Round-robin car mover: each game tick visits every car once, probes the collision mask
// for its requested one-pixel step and commits the step if walkable and unobstructed.
module car_move_sched
   import car_sched_pkg::*;
#(
   parameter int unsigned N_CARS    = 2,
   parameter int unsigned TICK_DIV  = 262144,
   parameter int unsigned CAR_W     = car_sched_pkg::CAR_W,
   parameter int unsigned CAR_H     = car_sched_pkg::CAR_H,
   parameter int unsigned MAX_X     = car_sched_pkg::MAX_X,
   parameter int unsigned MAX_Y     = car_sched_pkg::MAX_Y,
   parameter int unsigned PROBE_LAT = 2,
   parameter logic [11*N_CARS-1:0] INIT_X = {11'd416, 11'd416},
   parameter logic [10*N_CARS-1:0] INIT_Y = {10'd256, 10'd192}
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4*N_CARS-1:0]    dir_req_i,
   input  logic                   walkable_i,
   output logic                   probe_valid_o,
   output logic [10:0]            probe_x_o,
   output logic [9:0]             probe_y_o,
   output logic [11*N_CARS-1:0]   pos_x_o,
   output logic [10*N_CARS-1:0]   pos_y_o,
   output logic                   tick_o,
   output logic                   busy_o,
   output logic                   overrun_o
);

   localparam int unsigned IdxW     = (N_CARS > 1) ? $clog2(N_CARS) : 1;
   localparam int unsigned WaitLast = (PROBE_LAT > 2) ? PROBE_LAT - 2 : 0;
   localparam int unsigned WaitW    = (WaitLast > 0) ? $clog2(WaitLast + 1) : 1;
   localparam logic [11:0] CarW12   = 12'(CAR_W);
   localparam logic [11:0] CarH12   = 12'(CAR_H);
   localparam logic [11:0] MaxX12   = 12'(MAX_X);
   localparam logic [11:0] MaxY12   = 12'(MAX_Y);

   sched_state_t      state_q;
   dir_t              dir_q, sel_dir;
   logic [IdxW-1:0]   cur_q, rr_q, visit_q, cur_nxt, rr_nxt;
   logic [WaitW-1:0]  wait_q;
   logic [10:0]       px_q [N_CARS];
   logic [9:0]        py_q [N_CARS];
   logic              probe_valid_q, overrun_q, tick;
   logic [10:0]       probe_x_q, sel_px;
   logic [9:0]        probe_y_q, sel_py;
   logic [3:0]        req;
   logic [11:0]       cx, cy, nx, ny, ox, oy;
   logic              sel_ok, hit, advance, last_visit;

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   // Direction decode and legality for the car under SELECT, 12-bit so edges never wrap.
   always_comb begin
      req     = dir_req_i[{cur_q, 2'b00} +: 4];
      cx      = {1'b0, px_q[cur_q]};
      cy      = {2'b0, py_q[cur_q]};
      sel_ok  = 1'b0;
      sel_dir = DirUp;
      sel_px  = px_q[cur_q];
      sel_py  = py_q[cur_q];
      if (req[3]) begin
         sel_dir = DirUp;
         sel_ok  = (cy >= 12'd1);
         sel_py  = 10'(cy - 12'd1);
      end else if (req[2]) begin
         sel_dir = DirDown;
         sel_ok  = (cy + CarH12 <= MaxY12);
         sel_py  = 10'(cy + CarH12);
      end else if (req[1]) begin
         sel_dir = DirLeft;
         sel_ok  = (cx >= 12'd1);
         sel_px  = 11'(cx - 12'd1);
      end else if (req[0]) begin
         sel_dir = DirRight;
         sel_ok  = (cx + CarW12 <= MaxX12);
         sel_px  = 11'(cx + CarW12);
      end
   end

   // Candidate box after the step, tested against every other car's current box.
   always_comb begin
      nx  = cx;
      ny  = cy;
      ox  = '0;
      oy  = '0;
      hit = 1'b0;
      unique case (dir_q)
         DirUp:    ny = cy - 12'd1;
         DirDown:  ny = cy + 12'd1;
         DirLeft:  nx = cx - 12'd1;
         DirRight: nx = cx + 12'd1;
         default:  nx = cx;
      endcase
      for (int j = 0; j < N_CARS; j++) begin
         if (IdxW'(j) != cur_q) begin
            ox = {1'b0, px_q[j]};
            oy = {2'b0, py_q[j]};
            if ((nx < ox + CarW12) && (ox < nx + CarW12) &&
                (ny < oy + CarH12) && (oy < ny + CarH12)) begin
               hit = 1'b1;
            end
         end
      end
   end

   always_comb begin
      cur_nxt    = (cur_q == IdxW'(N_CARS - 1)) ? '0 : cur_q + 1'b1;
      rr_nxt     = (rr_q == IdxW'(N_CARS - 1)) ? '0 : rr_q + 1'b1;
      last_visit = (visit_q == IdxW'(N_CARS - 1));
      advance    = ((state_q == StSelect) && !sel_ok) || (state_q == StCommit);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= StIdle;
         dir_q         <= DirUp;
         cur_q         <= '0;
         rr_q          <= '0;
         visit_q       <= '0;
         wait_q        <= '0;
         probe_valid_q <= 1'b0;
         probe_x_q     <= '0;
         probe_y_q     <= '0;
         overrun_q     <= 1'b0;
         for (int i = 0; i < N_CARS; i++) begin
            px_q[i] <= INIT_X[i*11 +: 11];
            py_q[i] <= INIT_Y[i*10 +: 10];
         end
      end else begin
         probe_valid_q <= 1'b0;
         if (tick && (state_q != StIdle)) begin
            overrun_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (tick) begin
                  state_q <= StSelect;
                  cur_q   <= rr_q;
                  visit_q <= '0;
               end
            end
            StSelect: begin
               if (sel_ok) begin
                  state_q       <= StProbe;
                  dir_q         <= sel_dir;
                  probe_valid_q <= 1'b1;
                  probe_x_q     <= sel_px;
                  probe_y_q     <= sel_py;
               end
            end
            StProbe: begin
               state_q <= StWait;
               wait_q  <= '0;
            end
            StWait: begin
               if (wait_q == WaitW'(WaitLast)) begin
                  state_q <= StCommit;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            StCommit: begin
               if (walkable_i && !hit) begin
                  px_q[cur_q] <= nx[10:0];
                  py_q[cur_q] <= ny[9:0];
               end
            end
            default: state_q <= StIdle;
         endcase
         if (advance) begin
            if (last_visit) begin
               state_q <= StIdle;
               rr_q    <= rr_nxt;
            end else begin
               state_q <= StSelect;
               cur_q   <= cur_nxt;
               visit_q <= visit_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_CARS; i++) begin
         pos_x_o[i*11 +: 11] = px_q[i];
         pos_y_o[i*10 +: 10] = py_q[i];
      end
   end

   assign probe_valid_o = probe_valid_q;
   assign probe_x_o     = probe_x_q;
   assign probe_y_o     = probe_y_q;
   assign tick_o        = tick;
   assign busy_o        = (state_q != StIdle);
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_car_move_sched.sv
// Bench for car_move_sched: directed latency/boundary steps plus random passes checked
// against a pass-level model of the movement rules.
module tb_car_move_sched;

   localparam int N_CARS = 2;
   localparam int CAR_W  = 51;
   localparam int CAR_H  = 30;
   localparam int MAX_X  = 1279;
   localparam int MAX_Y  = 799;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rst_b = 1'b0;
   logic [7:0]  dir_a = '0;
   logic [7:0]  dir_b = 8'b0001_0001;
   logic        walk_a = 1'b0;
   logic        walk_b = 1'b1;
   logic        probe_valid_a, tick_a, busy_a, overrun_a;
   logic [10:0] probe_x_a;
   logic [9:0]  probe_y_a;
   logic [21:0] pos_x_a;
   logic [19:0] pos_y_a;
   logic        probe_valid_b, tick_b, busy_b, overrun_b;
   logic [10:0] probe_x_b;
   logic [9:0]  probe_y_b;
   logic [21:0] pos_x_b;
   logic [19:0] pos_y_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_tick_cyc = 0;
   int mode_a = 1;
   int mx[N_CARS];
   int my[N_CARS];
   int mrr = 0;
   int exp_px[$];
   int exp_py[$];
   int got_px[$];
   int got_py[$];
   bit prev_busy_b = 1'b0;
   bit first_pending = 1'b0;
   bit ov_seen = 1'b0;
   int ov_drop = 0;
   int pass_b = 0;

   always #5 clk = ~clk;

   car_move_sched #(
      .N_CARS    (2),
      .TICK_DIV  (16),
      .PROBE_LAT (2)
   ) dut_a (
      .clk           (clk),
      .rst           (rst),
      .dir_req_i     (dir_a),
      .walkable_i    (walk_a),
      .probe_valid_o (probe_valid_a),
      .probe_x_o     (probe_x_a),
      .probe_y_o     (probe_y_a),
      .pos_x_o       (pos_x_a),
      .pos_y_o       (pos_y_a),
      .tick_o        (tick_a),
      .busy_o        (busy_a),
      .overrun_o     (overrun_a)
   );

   car_move_sched #(
      .N_CARS    (2),
      .TICK_DIV  (4),
      .PROBE_LAT (2)
   ) dut_b (
      .clk           (clk),
      .rst           (rst_b),
      .dir_req_i     (dir_b),
      .walkable_i    (walk_b),
      .probe_valid_o (probe_valid_b),
      .probe_x_o     (probe_x_b),
      .probe_y_o     (probe_y_b),
      .pos_x_o       (pos_x_b),
      .pos_y_o       (pos_y_b),
      .tick_o        (tick_b),
      .busy_o        (busy_b),
      .overrun_o     (overrun_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit mask(input int x, input int y, input int mode);
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      return ((x * 3 + y * 5) % 7) != 0;
   endfunction

   function automatic bit collides(input int c, input int nx, input int ny);
      for (int o = 0; o < N_CARS; o++) begin
         if (o != c && nx < mx[o] + CAR_W && mx[o] < nx + CAR_W &&
             ny < my[o] + CAR_H && my[o] < ny + CAR_H) return 1'b1;
      end
      return 1'b0;
   endfunction

   // One whole pass of the movement rules, car by car in round-robin order.
   task automatic model_pass(input logic [7:0] dirs, input int mode);
      exp_px.delete();
      exp_py.delete();
      for (int k = 0; k < N_CARS; k++) begin
         int c, dx, dy, tx, ty;
         bit legal;
         logic [3:0] r;
         c = (mrr + k) % N_CARS;
         r = dirs[c*4 +: 4];
         dx = 0; dy = 0; tx = mx[c]; ty = my[c]; legal = 1'b0;
         if (r[3]) begin dy = -1; ty = my[c] - 1; legal = (my[c] >= 1); end
         else if (r[2]) begin dy = 1; ty = my[c] + CAR_H; legal = (my[c] + CAR_H <= MAX_Y); end
         else if (r[1]) begin dx = -1; tx = mx[c] - 1; legal = (mx[c] >= 1); end
         else if (r[0]) begin dx = 1; tx = mx[c] + CAR_W; legal = (mx[c] + CAR_W <= MAX_X); end
         if (legal) begin
            exp_px.push_back(tx);
            exp_py.push_back(ty);
            if (mask(tx, ty, mode) && !collides(c, mx[c] + dx, my[c] + dy)) begin
               mx[c] += dx;
               my[c] += dy;
            end
         end
      end
      mrr = (mrr + 1) % N_CARS;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (probe_valid_a === 1'b1) begin
         got_px.push_back(int'(probe_x_a));
         got_py.push_back(int'(probe_y_a));
         walk_a = mask(int'(probe_x_a), int'(probe_y_a), mode_a);
      end
      if (rst_b) begin
         if (busy_b && !prev_busy_b) first_pending = 1'b1;
         if (probe_valid_b && first_pending) begin
            first_pending = 1'b0;
            check("rr_first_car", 32'(probe_y_b), (pass_b % 2 == 0) ? 192 : 256);
            pass_b++;
         end
         if (overrun_b) ov_seen = 1'b1;
         else if (ov_seen) ov_drop++;
         prev_busy_b = busy_b;
      end
   endtask

   task automatic check_pos(input string tag);
      check({tag, "_x0"}, 32'(pos_x_a[10:0]), mx[0]);
      check({tag, "_y0"}, 32'(pos_y_a[9:0]), my[0]);
      check({tag, "_x1"}, 32'(pos_x_a[21:11]), mx[1]);
      check({tag, "_y1"}, 32'(pos_y_a[19:10]), my[1]);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      mx[0] = 416; my[0] = 192;
      mx[1] = 416; my[1] = 256;
      mrr = 0;
      got_px.delete();
      got_py.delete();
   endtask

   task automatic wait_tick(input string tag);
      int n;
      n = 0;
      step();
      while (tick_a !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check(tag, 32'(tick_a), 1);
      last_tick_cyc = cyc;
   endtask

   // Waits for the next tick, lets the pass run out, then compares probes and positions.
   task automatic run_pass(input logic [7:0] dirs, input int mode, input string tag,
                           output int busy_cycles, output int period);
      int prev;
      prev = last_tick_cyc;
      dir_a = dirs;
      mode_a = mode;
      model_pass(dirs, mode);
      got_px.delete();
      got_py.delete();
      wait_tick({tag, "_tick"});
      period = cyc - prev;
      busy_cycles = 0;
      step();
      while (busy_a === 1'b1 && busy_cycles < 40) begin
         busy_cycles++;
         step();
      end
      check({tag, "_idle"}, 32'(busy_a), 0);
      check({tag, "_nprobe"}, got_px.size(), exp_px.size());
      for (int i = 0; i < exp_px.size() && i < got_px.size(); i++) begin
         check({tag, "_probe_x"}, got_px[i], exp_px[i]);
         check({tag, "_probe_y"}, got_py[i], exp_py[i]);
      end
      check_pos(tag);
   endtask

   initial begin
      int bc, per;
      // Reset values, sampled while reset is still asserted.
      rst = 1'b0;
      step();
      step();
      check("rst_pos_x0", 32'(pos_x_a[10:0]), 416);
      check("rst_pos_y0", 32'(pos_y_a[9:0]), 192);
      check("rst_pos_x1", 32'(pos_x_a[21:11]), 416);
      check("rst_pos_y1", 32'(pos_y_a[19:10]), 256);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_tick", 32'(tick_a), 0);
      check("rst_overrun", 32'(overrun_a), 0);
      check("rst_probe_valid", 32'(probe_valid_a), 0);
      check("rst_probe_x", 32'(probe_x_a), 0);
      check("rst_probe_y", 32'(probe_y_a), 0);
      do_reset();

      // Empty passes: every car skipped, tick period of 16.
      run_pass(8'h00, 1, "empty1", bc, per);
      check("empty1_busy", bc, 2);
      run_pass(8'h00, 1, "empty2", bc, per);
      check("tick_period", per, 16);
      check("empty2_busy", bc, 2);

      // Car0 right into a non-walkable pixel.
      run_pass(8'b0000_0001, 0, "right_blocked", bc, per);
      check("right_blocked_px", exp_px.size() > 0 ? got_px.size() > 0 ? got_px[0] : -1 : -1, 467);
      run_pass(8'h00, 1, "empty3", bc, per);

      // Latency pass with car0 first in round-robin order.
      dir_a = 8'b0000_1000;
      mode_a = 1;
      model_pass(dir_a, 1);
      wait_tick("lat_tick");
      step(); check("lat_pv_t1", 32'(probe_valid_a), 0);
      step(); check("lat_pv_t2", 32'(probe_valid_a), 1);
      check("lat_probe_x", 32'(probe_x_a), 416);
      check("lat_probe_y", 32'(probe_y_a), 191);
      step(); check("lat_pv_t3", 32'(probe_valid_a), 0);
      check("hold_probe_x", 32'(probe_x_a), 416);
      check("hold_probe_y", 32'(probe_y_a), 191);
      step(); check("lat_y_t4", 32'(pos_y_a[9:0]), 192);
      step(); check("lat_y_t5", 32'(pos_y_a[9:0]), 191);
      bc = 0;
      while (busy_a === 1'b1 && bc < 40) begin bc++; step(); end
      check_pos("lat");

      // Random passes against the model.
      for (int p = 0; p < 30; p++) begin
         run_pass(8'($urandom), int'($urandom_range(2, 0)), "rand", bc, per);
      end

      // Reset landing in WAIT must abort the pending commit.
      do_reset();
      dir_a = 8'b0000_1000;
      mode_a = 1;
      wait_tick("abort_tick");
      bc = 0;
      while (probe_valid_a !== 1'b1 && bc < 10) begin step(); bc++; end
      check("abort_probe_seen", 32'(probe_valid_a), 1);
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      step(); step(); step();
      check("abort_y0", 32'(pos_y_a[9:0]), 192);
      check("abort_busy", 32'(busy_a), 0);
      do_reset();

      // Drive car0 to the left edge, then an illegal left is skipped without a probe.
      for (int p = 0; p < 416; p++) run_pass(8'b0000_0010, 1, "left", bc, per);
      check("left_edge_x0", 32'(pos_x_a[10:0]), 0);
      run_pass(8'b0000_0010, 1, "left_illegal", bc, per);
      check("left_illegal_busy", bc, 2);
      check("left_illegal_nprobe", got_px.size(), 0);

      // Car0 moves down until it touches car1, then is refused by overlap.
      do_reset();
      for (int p = 0; p < 33; p++) run_pass(8'b0000_0100, 1, "down", bc, per);
      check("down_y0_225", 32'(pos_y_a[9:0]), 225);
      run_pass(8'b0000_0100, 1, "down_touch", bc, per);
      check("down_touch_probe_y", got_py.size() > 0 ? got_py[0] : -1, 255);
      check("down_touch_y0", 32'(pos_y_a[9:0]), 226);
      run_pass(8'b0000_0100, 1, "down_overlap", bc, per);
      check("down_overlap_y0", 32'(pos_y_a[9:0]), 226);
      dir_a = '0;

      // Fast ticks on the second instance: overrun is sticky, first car alternates.
      rst_b = 1'b1;
      for (int i = 0; i < 300; i++) step();
      check("b_overrun", 32'(overrun_b), 1);
      check("b_overrun_sticky", ov_drop, 0);
      check("b_passes", 32'(pass_b >= 4), 1);
      rst_b = 1'b0;
      step();
      check("b_overrun_rst", 32'(overrun_b), 0);
      rst_b = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
